// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter feeding a 4-bit alu through an IDLE/EXEC/RESP fsm
// Contains the team alu and the alu_arbiter top.

module alu (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       carry
);
    always_comb begin
        result = 4'd0;
        carry  = 1'b0;
        case (op)
            3'b000: {carry, result} = {1'b0, a} + {1'b0, b};
            3'b001: begin
                result = a - b;
                carry  = (a < b);
            end
            3'b010: result = a & b;
            3'b011: result = a | b;
            3'b100: result = a ^ b;
            3'b101: result = ~a;
            3'b110: result = {1'b0, a[3:1]};
            3'b111: result = {a[2:0], 1'b0};
            default: result = 4'd0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic       rsp_carry,
    output logic       rsp_id,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    state_t     state_next;
    logic       last_grant;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [2:0] op_q;
    logic       id_q;
    logic       win0;
    logic       win1;
    logic       handshake;
    logic [3:0] alu_result;
    logic       alu_carry;

    alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    // last_grant==0 means requester 0 was granted last, so requester 1 wins a tie
    always_comb begin
        win1 = req1_valid & (~req0_valid | (RR_EN & ~last_grant));
        win0 = req0_valid & ~win1;
    end

    assign req0_ready = rst_n & (state == IDLE) & win0;
    assign req1_ready = rst_n & (state == IDLE) & win1;
    assign handshake  = req0_ready | req1_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (rsp_valid & rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            a_q        <= 4'd0;
            b_q        <= 4'd0;
            op_q       <= 3'd0;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= 4'd0;
            rsp_carry  <= 1'b0;
            rsp_id     <= 1'b0;
        end else begin
            state <= state_next;
            if (handshake) begin
                a_q        <= win1 ? req1_a  : req0_a;
                b_q        <= win1 ? req1_b  : req0_b;
                op_q       <= win1 ? req1_op : req0_op;
                id_q       <= win1;
                last_grant <= win1;
            end
            if (state == EXEC) begin
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                rsp_id     <= id_q;
                rsp_valid  <= 1'b1;
            end else if (rsp_valid & rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural arbitration and alu model

module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;
    logic       req0_ready, req1_ready, rsp_valid, rsp_carry, rsp_id, busy;
    logic [3:0] rsp_result;
    logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_carry, fp_rsp_id, fp_busy;
    logic [3:0] fp_rsp_result;

    always #5 clk = ~clk;

    alu_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_id(rsp_id), .busy(busy)
    );

    alu_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(fp_rsp_result), .rsp_carry(fp_rsp_carry),
        .rsp_id(fp_rsp_id), .busy(fp_busy)
    );

    typedef struct {
        int result;
        int carry;
        int id;
        int due;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   outstanding = 0;
    int   last = 1;
    bit   fixed_phase = 0;
    bit   seen = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t alu_model(input int op, input int a, input int b, input int id);
        exp_t e;
        e.id = id;
        e.carry = 0;
        case (op)
            0: begin e.result = (a + b) % 16; e.carry = (a + b > 15) ? 1 : 0; end
            1: begin e.result = (a - b + 16) % 16; e.carry = (a < b) ? 1 : 0; end
            2: e.result = a & b;
            3: e.result = a | b;
            4: e.result = a ^ b;
            5: e.result = 15 - a;
            6: e.result = a / 2;
            default: e.result = (a * 2) % 16;
        endcase
        e.due = 0;
        return e;
    endfunction

    // One cycle: check grants against the model at negedge, then return 1 time unit after posedge
    task automatic cycle_check();
        int w;
        exp_t e;
        @(negedge clk);
        w = -1;
        if (!outstanding) begin
            if (req0_valid && req1_valid) w = (last == 1) ? 0 : 1;
            else if (req0_valid) w = 0;
            else if (req1_valid) w = 1;
        end
        check("ready", {30'd0, req1_ready, req0_ready},
              (w == 0) ? 1 : (w == 1) ? 2 : 0);
        check("busy", int'(busy), int'(outstanding));
        if (req0_valid) check("fixed_prio_ready1", int'(fp_req1_ready), 0);
        if (w == 0) e = alu_model(int'(req0_op), int'(req0_a), int'(req0_b), 0);
        if (w == 1) e = alu_model(int'(req1_op), int'(req1_a), int'(req1_b), 1);
        if (w >= 0) begin
            e.due = cyc + 2;
            q.push_back(e);
            outstanding = 1;
            last = w;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready = 1;
        for (int i = 0; i < 20 && (outstanding || q.size() != 0); i++) cycle_check();
        if (outstanding || q.size() != 0) check("drain_timeout", 1, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_rsp_result", int'(rsp_result), 0);
        check("rst_rsp_carry", int'(rsp_carry), 0);
        check("rst_rsp_id", int'(rsp_id), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fp_outputs", int'({fp_rsp_valid, fp_rsp_result, fp_rsp_carry, fp_rsp_id, fp_busy}), 0);
    endtask

    // Monitor: compares every presented response against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                seen = 0;
            end else begin
                if (fixed_phase && fp_rsp_valid) check("fixed_prio_rsp_id", int'(fp_rsp_id), 0);
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        check("rsp_result", int'(rsp_result), q[0].result);
                        check("rsp_carry", int'(rsp_carry), q[0].carry);
                        check("rsp_id", int'(rsp_id), q[0].id);
                        if (!seen) check("latency", cyc, q[0].due);
                        seen = 1;
                        if (rsp_ready) begin
                            void'(q.pop_front());
                            outstanding = 0;
                            seen = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 0;
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        check("rst_ready_idle", int'({req1_ready, req0_ready}), 0);
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        #1;
        check("rst_ready_with_valid", int'({req1_ready, req0_ready, fp_req1_ready, fp_req0_ready}), 0);
        req0_valid = 0; req1_valid = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) cycle_check();

        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 3'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 3'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            cycle_check();
        end
        drain();

        rst_n = 0;
        #1;
        check_reset_outputs();
        q.delete(); outstanding = 0; last = 1;
        @(posedge clk);
        #1;
        rst_n = 1;

        req0_valid = 1; req0_a = 9; req0_b = 8; req0_op = 0; rsp_ready = 1;
        cycle_check();
        drain();

        req1_valid = 1; req1_a = 3; req1_b = 5; req1_op = 1; rsp_ready = 0;
        cycle_check();
        for (int i = 0; i < 7; i++) begin
            req0_valid = 1; req1_valid = 1;
            req0_a = 4'($urandom); req1_a = 4'($urandom); req0_op = 3'($urandom); req1_op = 3'($urandom);
            cycle_check();
        end
        drain();
        cycle_check();

        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) fixed_phase = 1;
            req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 3'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 3'($urandom);
            cycle_check();
        end
        fixed_phase = 0;
        drain();

        req0_valid = 1; req0_a = 7; req0_b = 2; req0_op = 4; rsp_ready = 1;
        cycle_check();
        req0_valid = 0;
        rst_n = 0;
        #1;
        check("mid_exec_busy", int'(busy), 0);
        check("mid_exec_rsp_valid", int'(rsp_valid), 0);
        q.delete(); outstanding = 0; last = 1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 5; i++) cycle_check();
        req0_valid = 1; req1_valid = 1;
        cycle_check();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
